// File: rtl/ray_column_buffer.sv
// ray_column_buffer: double-banked per-column wall span store with a 2-cycle pixel lookup.
// Define RCB_PARTIAL_SWAP_EN to let frame_swap_in swap an incomplete write bank.
module ray_column_buffer #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        dda_valid_in,
  output logic        dda_tready_out,
  input  logic [8:0]  hcount_ray_in,
  input  logic [7:0]  lineHeight_in,
  input  logic        wallType_in,
  input  logic [3:0]  mapData_in,
  input  logic [15:0] wallX_in,
  input  logic        frame_swap_in,
  input  logic        read_valid_in,
  input  logic [8:0]  hcount_in,
  input  logic [7:0]  vcount_in,
  output logic        pixel_valid_out,
  output logic        pixel_is_wall_out,
  output logic        pixel_wallType_out,
  output logic [3:0]  pixel_mapData_out,
  output logic [15:0] pixel_wallX_out,
  output logic        frame_complete_out,
  output logic        range_err_out
);
  localparam logic [8:0] SW = 9'(SCREEN_WIDTH);
  localparam logic [7:0] SH = 8'(SCREEN_HEIGHT);
  typedef struct packed {
    logic [7:0]  ds;
    logic [7:0]  de;
    logic        z;
    logic        wt;
    logic [3:0]  md;
    logic [15:0] wx;
  } entry_t;
  entry_t mem [2][SCREEN_WIDTH];
  logic [SCREEN_WIDTH-1:0] vld [2];
  logic wbank, full, swap, accept;
  logic [8:0] count;
  logic s1_v, s1_wt;
  logic [8:0] s1_col;
  logic [7:0] s1_lh, ds;
  logic [3:0] s1_md;
  logic [15:0] s1_wx;
  entry_t s1_e, r1_e;
  logic r1_v, r1_ok;
  logic [7:0] r1_vc;
  logic [8:0] raddr;
  assign full = count == SW;
  assign dda_tready_out = ~full & ~frame_swap_in;
  assign accept = dda_valid_in & dda_tready_out;
  assign frame_complete_out = full;
  assign raddr = hcount_in < SW ? hcount_in : '0;
  assign ds = (SH - s1_lh) >> 1;
  assign s1_e = {ds, ds + s1_lh - 8'd1, s1_lh == 8'd0, s1_wt, s1_md, s1_wx};
`ifdef RCB_PARTIAL_SWAP_EN
  assign swap = frame_swap_in;
`else
  assign swap = frame_swap_in & full;
`endif
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wbank <= 1'b0;
      count <= '0;
      vld[0] <= '0;
      vld[1] <= '0;
      s1_v <= 1'b0;
      s1_col <= '0;
      s1_lh <= '0;
      s1_wt <= 1'b0;
      s1_md <= '0;
      s1_wx <= '0;
      range_err_out <= 1'b0;
      r1_v <= 1'b0;
      r1_ok <= 1'b0;
      r1_vc <= '0;
      pixel_valid_out <= 1'b0;
      pixel_is_wall_out <= 1'b0;
      pixel_wallType_out <= 1'b0;
      pixel_mapData_out <= '0;
      pixel_wallX_out <= '0;
    end else begin
      s1_v <= accept & (hcount_ray_in < SW);
      range_err_out <= range_err_out | (accept & (hcount_ray_in >= SW));
      if (accept) begin
        s1_col <= hcount_ray_in;
        s1_lh <= lineHeight_in > SH ? SH : lineHeight_in;
        s1_wt <= wallType_in;
        s1_md <= mapData_in;
        s1_wx <= wallX_in;
      end
      if (s1_v) begin
        vld[wbank][s1_col] <= 1'b1;
        if (!vld[wbank][s1_col]) count <= count + 9'd1;
      end
      // the in-flight write above still lands in the old bank; only the other bank is cleared
      if (swap) begin
        wbank <= ~wbank;
        count <= '0;
        vld[~wbank] <= '0;
      end
      r1_v <= read_valid_in;
      r1_vc <= vcount_in;
      r1_ok <= (hcount_in < SW) && vld[~wbank][raddr];
      pixel_valid_out <= r1_v;
      if (r1_v) begin
        pixel_is_wall_out <= r1_ok & ~r1_e.z & (r1_e.ds <= r1_vc) & (r1_vc <= r1_e.de);
        pixel_wallType_out <= r1_ok & r1_e.wt;
        pixel_mapData_out <= r1_ok ? r1_e.md : '0;
        pixel_wallX_out <= r1_ok ? r1_e.wx : '0;
      end
    end
  end
  always_ff @(posedge pixel_clk_in) begin
    if (s1_v) mem[wbank][s1_col] <= s1_e;
    r1_e <= mem[~wbank][raddr];
  end
endmodule

// File: tb/tb_ray_column_buffer.sv
// tb_ray_column_buffer: scoreboard bench for ray_column_buffer (either RCB_PARTIAL_SWAP_EN setting).
module tb_ray_column_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic dda_valid = 1'b0, tready, wt = 1'b0, swap = 1'b0, rv = 1'b0;
  logic [8:0] hray = '0, hc = '0;
  logic [7:0] lh = '0, vc = '0;
  logic [3:0] md = '0, pmd;
  logic [15:0] wx = '0, pwx;
  logic pv, pw, pwt, fc, rerr;
  int checks = 0, fails = 0, cyc = 0;
  typedef struct {
    logic w;
    logic wt;
    logic [3:0] md;
    logic [15:0] wx;
    int at;
    string name;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  ray_column_buffer dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .dda_valid_in(dda_valid), .dda_tready_out(tready),
    .hcount_ray_in(hray), .lineHeight_in(lh), .wallType_in(wt),
    .mapData_in(md), .wallX_in(wx), .frame_swap_in(swap),
    .read_valid_in(rv), .hcount_in(hc), .vcount_in(vc),
    .pixel_valid_out(pv), .pixel_is_wall_out(pw), .pixel_wallType_out(pwt),
    .pixel_mapData_out(pmd), .pixel_wallX_out(pwx),
    .frame_complete_out(fc), .range_err_out(rerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pv) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected pixel_valid_out: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        chk({e.name, " latency"}, cyc, e.at);
        chk({e.name, " {wall,type,map,wallX}"}, {pw, pwt, pmd, pwx}, {e.w, e.wt, e.md, e.wx});
      end
    end
  end

  task automatic lk(input string n, input int h, input int v, input logic w, input logic t,
                    input logic [3:0] m, input logic [15:0] x);
    rv = 1'b1;
    hc = 9'(h);
    vc = 8'(v);
    sb.push_back('{w, t, m, x, cyc + 2, n});
    @(negedge clk);
    rv = 1'b0;
  endtask

  task automatic wr(input int c, input logic [7:0] l, input logic [3:0] m, input logic [15:0] x);
    dda_valid = 1'b1;
    hray = 9'(c);
    lh = l;
    wt = hray[0];
    md = m;
    wx = x;
    @(negedge clk);
    dda_valid = 1'b0;
  endtask

  task automatic fill(input int lo, input int hi, input logic [7:0] l, input logic [3:0] m);
    for (int c = lo; c <= hi; c++) wr(c, l, m, 16'(c * 7));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_swap(input string n);
    swap = 1'b1;
    #1 chk({n, " tready during swap"}, tready, 0);
    @(negedge clk);
    swap = 1'b0;
    #1 chk({n, " tready after swap"}, tready, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2 chk("reset outputs", {pv, pw, pwt, pmd, pwx, fc, rerr}, 0);
    chk("reset tready", tready, 1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    // basic frame, lineHeight 100 -> rows 40..139
    fill(0, 318, 100, 5);
    idle(2);
    chk("t1 fc at 319", fc, 0);
    wr(319, 100, 5, 16'(319 * 7));
    idle(2);
    chk("t1 fc at 320", fc, 1);
    chk("t1 tready full", tready, 0);
    do_swap("t1");
    chk("t1 fc cleared", fc, 0);
    lk("t1 (5,40)", 5, 40, 1, 1, 5, 35);
    lk("t1 (5,39)", 5, 39, 0, 1, 5, 35);
    lk("t1 (5,140)", 5, 140, 0, 1, 5, 35);
    lk("t1 (5,139)", 5, 139, 1, 1, 5, 35);
    lk("t1 (320,50)", 320, 50, 0, 0, 0, 0);
    lk("t1 (319,100)", 319, 100, 1, 1, 5, 2233);
    idle(3);
    chk("t1 valid drops", pv, 0);
    chk("t1 wallX holds", pwx, 2233);
    // height edge cases and an out-of-range column
    wr(0, 0, 10, 0);
    wr(1, 1, 11, 7);
    wr(2, 180, 12, 14);
    wr(3, 255, 13, 21);
    fill(4, 318, 100, 4);
    wr(400, 100, 4, 0);
    idle(2);
    chk("t2 fc after col 400", fc, 0);
    chk("t2 range_err set", rerr, 1);
    wr(319, 100, 4, 2233);
    idle(2);
    chk("t2 fc full", fc, 1);
    do_swap("t2");
    lk("t2 (0,90)", 0, 90, 0, 0, 10, 0);
    lk("t2 (1,89)", 1, 89, 1, 1, 11, 7);
    lk("t2 (1,88)", 1, 88, 0, 1, 11, 7);
    lk("t2 (1,90)", 1, 90, 0, 1, 11, 7);
    lk("t2 (2,0)", 2, 0, 1, 0, 12, 14);
    lk("t2 (2,179)", 2, 179, 1, 0, 12, 14);
    lk("t2 (3,0)", 3, 0, 1, 1, 13, 21);
    lk("t2 (3,179)", 3, 179, 1, 1, 13, 21);
    lk("t2 (4,40)", 4, 40, 1, 0, 4, 28);
    idle(3);
    // duplicate column 7
    fill(0, 6, 100, 3);
    wr(7, 100, 3, 49);
    wr(7, 100, 9, 49);
    fill(8, 318, 100, 3);
    idle(2);
    chk("t3 fc with duplicate", fc, 0);
    wr(319, 100, 3, 2233);
    idle(2);
    chk("t3 fc full", fc, 1);
    do_swap("t3");
    lk("t3 (7,50)", 7, 50, 1, 1, 9, 49);
    lk("t3 (8,50)", 8, 50, 1, 0, 3, 56);
    chk("t3 range_err sticky", rerr, 1);
    idle(3);
    // swap request with 319 columns
    fill(0, 318, 180, 2);
    idle(2);
    chk("t4 fc at 319", fc, 0);
    do_swap("t4");
`ifdef RCB_PARTIAL_SWAP_EN
    lk("t4 (10,20)", 10, 20, 1, 0, 2, 70);
    lk("t4 (319,50)", 319, 50, 0, 0, 0, 0);
    idle(3);
    fill(0, 319, 180, 2);
`else
    lk("t4 (10,20)", 10, 20, 0, 0, 3, 70);
    lk("t4 (319,50)", 319, 50, 1, 1, 3, 2233);
    idle(3);
    wr(319, 180, 2, 2233);
`endif
    idle(2);
    chk("t4 fc full", fc, 1);
    // backpressure while full, then swap with valid held
    dda_valid = 1'b1;
    hray = 9'd5;
    lh = 8'd0;
    wt = 1'b1;
    md = 4'd15;
    wx = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("t5 tready full", tready, 0);
    end
    do_swap("t5");
    dda_valid = 1'b0;
    lk("t5 (5,100) no write", 5, 100, 1, 1, 2, 35);
    fill(0, 4, 60, 6);
    fill(6, 319, 60, 6);
    idle(2);
    chk("t5 fc full", fc, 1);
    do_swap("t5b");
    lk("t5 (5,100)", 5, 100, 0, 1, 15, 16'hABCD);
    lk("t5 (6,60)", 6, 60, 1, 0, 6, 42);
    lk("t5 (6,59)", 6, 59, 0, 0, 6, 42);
    idle(3);
    // async reset mid-frame
    fill(0, 9, 100, 1);
    wr(400, 100, 1, 0);
    lk("t6 (2,60)", 2, 60, 1, 0, 6, 14);
    idle(3);
    chk("t6 range_err", rerr, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6 reset outputs", {pv, pw, pwt, pmd, pwx, fc, rerr}, 0);
    chk("t6 reset tready", tready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    lk("t6 (2,60) after reset", 2, 60, 0, 0, 0, 0);
    fill(0, 318, 100, 1);
    idle(2);
    chk("t6 fc at 319", fc, 0);
    wr(319, 100, 1, 2233);
    idle(2);
    chk("t6 fc full", fc, 1);
    idle(3);
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
